// File: rtl/sig_capture_ctrl_if.sv
// Store-snoop, drain and status bundle for sig_capture_ctrl.
// master: core/bench side; slave: the capture controller.
interface sig_capture_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              st_en;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              rd_en;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [LW-1:0]     level;
    logic              overflow;
    logic              halted;
    logic              timed_out;
    logic              done;
    logic [31:0]       cycles;

    modport master (
        output st_en, st_addr, st_data, rd_en,
        input  rd_valid, rd_data, level,
        input  overflow, halted, timed_out, done, cycles
    );

    modport slave (
        input  st_en, st_addr, st_data, rd_en,
        output rd_valid, rd_data, level,
        output overflow, halted, timed_out, done, cycles
    );
endinterface

// File: rtl/sig_capture_ctrl.sv
// Signature capture / halt / timeout controller snooping the store port.
// Optional macro SIG_RANGE_EN: capture a SIG_SPAN-byte window, not one address.
module sig_capture_ctrl #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 16,
    parameter logic [ADDR_W-1:0] SIG_ADDR  = 32'h0000_0F00,
    parameter logic [ADDR_W-1:0] HALT_ADDR = 32'hCAFE_BEEF,
    parameter int                TIMEOUT   = 20000,
    parameter int                SIG_SPAN  = 64
) (
    input  logic               clk,
    input  logic               rst,
    sig_capture_ctrl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

`ifdef SIG_RANGE_EN
    localparam bit RANGE_ON = 1'b1;
`else
    localparam bit RANGE_ON = 1'b0;
`endif

    // Exact-match mode is a window of one address.
    localparam logic [ADDR_W-1:0] WIN =
        RANGE_ON ? ADDR_W'(SIG_SPAN) : ADDR_W'(1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wptr, rptr;
    logic [31:0]       cyc_q;
    logic              ovf_q, halt_q, tmo_q;

    logic [ADDR_W-1:0] sig_off;
    logic              halt_hit, sig_hit, tmo_hit;
    logic              run, empty, full;
    logic              do_push, do_pop, drop;
    logic              set_halt, set_tmo;

    assign sig_off  = bus.st_addr - SIG_ADDR;
    assign halt_hit = bus.st_en && (bus.st_addr == HALT_ADDR);
    assign sig_hit  = bus.st_en && !halt_hit &&
                      (bus.st_addr >= SIG_ADDR) && (sig_off < WIN);
    assign tmo_hit  = (cyc_q == TMO_LAST);

    assign run   = (state == S_RUN);
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) &&
                   (wptr[AW] != rptr[AW]);

    assign do_pop  = bus.rd_en && !empty;
    assign do_push = run && sig_hit && (!full || do_pop);
    assign drop    = run && sig_hit && full && !do_pop;

    always_comb begin
        state_nx = state;
        set_halt = 1'b0;
        set_tmo  = 1'b0;
        unique case (state)
            S_RUN: begin
                set_halt = halt_hit;
                set_tmo  = tmo_hit;
                if (halt_hit || tmo_hit)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (empty)
                    state_nx = S_DONE;
            end
            S_DONE: state_nx = S_DONE;
            default: state_nx = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Storage is cleared on reset so rd_data reads 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= bus.st_data;
                wptr <= wptr + 1'b1;
            end
            if (do_pop)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q  <= '0;
            ovf_q  <= 1'b0;
            halt_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            if (run && (cyc_q != 32'hFFFF_FFFF))
                cyc_q <= cyc_q + 32'd1;
            if (drop)
                ovf_q <= 1'b1;
            if (set_halt)
                halt_q <= 1'b1;
            if (set_tmo)
                tmo_q <= 1'b1;
        end
    end

    assign bus.rd_valid  = !empty;
    assign bus.rd_data   = mem[rptr[AW-1:0]];
    assign bus.level     = wptr - rptr;
    assign bus.overflow  = ovf_q;
    assign bus.halted    = halt_q;
    assign bus.timed_out = tmo_q;
    assign bus.done      = (state == S_DONE);
    assign bus.cycles    = cyc_q;
endmodule

// File: tb/tb_sig_capture_ctrl.sv
// Directed bench for sig_capture_ctrl: queue scoreboard on the drain port,
// direct checks on level and status flags.
module tb_sig_capture_ctrl;
    localparam int DEPTH = 4;
    localparam logic [31:0] SIG  = 32'h0000_0F00;
    localparam logic [31:0] HALT = 32'hCAFE_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sig_capture_ctrl_if #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)
    ) ifc ();

    sig_capture_ctrl #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH),
        .SIG_ADDR(SIG), .HALT_ADDR(HALT),
        .TIMEOUT(50), .SIG_SPAN(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Scoreboard monitor: every accepted pop is compared against the queue.
    always @(negedge clk) begin
        if (!rst && ifc.rd_en && ifc.rd_valid) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected: got %h expected none",
                         ifc.rd_data);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (ifc.rd_data === e)
                    n_pass++;
                else
                    $display("FAIL pop_data: got %h expected %h",
                             ifc.rd_data, e);
            end
        end
    end

    // One clock cycle with the given store/pop inputs; returns 1 after edge.
    task automatic step(input logic se, input logic [31:0] sa,
                        input logic [31:0] sd, input logic re);
        ifc.st_en   = se;
        ifc.st_addr = sa;
        ifc.st_data = sd;
        ifc.rd_en   = re;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        ifc.st_en   = 1'b0;
        ifc.st_addr = '0;
        ifc.st_data = '0;
        ifc.rd_en   = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.st_en   = 1'b0;
        ifc.st_addr = '0;
        ifc.st_data = '0;
        ifc.rd_en   = 1'b0;
        #3;
        chk("rst_rd_valid", 32'(ifc.rd_valid), 0);
        chk("rst_rd_data", ifc.rd_data, 0);
        chk("rst_level", 32'(ifc.level), 0);
        chk("rst_done", 32'(ifc.done), 0);
        chk("rst_cycles", ifc.cycles, 0);

        // Three stores then three pops.
        do_reset();
        step(1'b1, SIG, 32'h11, 1'b0); exp_q.push_back(32'h11);
        step(1'b1, SIG, 32'h22, 1'b0); exp_q.push_back(32'h22);
        step(1'b1, SIG, 32'h33, 1'b0); exp_q.push_back(32'h33);
        chk("t1_level3", 32'(ifc.level), 3);
        chk("t1_valid", 32'(ifc.rd_valid), 1);
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t1_valid_fall", 32'(ifc.rd_valid), 0);
        chk("t1_level0", 32'(ifc.level), 0);

        // Overflow on a depth-4 FIFO.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, SIG, 32'(i), 1'b0);
            if (i <= 4)
                exp_q.push_back(32'(i));
        end
        chk("t2_level_full", 32'(ifc.level), 4);
        chk("t2_overflow", 32'(ifc.overflow), 1);
        step(1'b1, SIG, 32'h7, 1'b1); exp_q.push_back(32'h7);
        chk("t2_pushpop_level", 32'(ifc.level), 4);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t2_drained", 32'(ifc.rd_valid), 0);
        chk("t2_ovf_sticky", 32'(ifc.overflow), 1);

        // Halt store, ignored later store, drain to done.
        do_reset();
        step(1'b1, SIG, 32'hA1, 1'b0); exp_q.push_back(32'hA1);
        step(1'b1, SIG, 32'hA2, 1'b0); exp_q.push_back(32'hA2);
        step(1'b1, HALT, 32'hDEAD, 1'b0);
        chk("t3_halted", 32'(ifc.halted), 1);
        chk("t3_level", 32'(ifc.level), 2);
        step(1'b1, SIG, 32'hBAD, 1'b0);
        chk("t3_ignored", 32'(ifc.level), 2);
        chk("t3_not_done", 32'(ifc.done), 0);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t3_done_late", 32'(ifc.done), 0);
        idle();
        chk("t3_done", 32'(ifc.done), 1);
        chk("t3_cycles", ifc.cycles, 3);
        chk("t3_no_tmo", 32'(ifc.timed_out), 0);

        // Timeout after 50 RUN cycles.
        do_reset();
        for (int i = 0; i < 49; i++)
            idle();
        chk("t4_cyc49", ifc.cycles, 49);
        chk("t4_no_tmo", 32'(ifc.timed_out), 0);
        idle();
        chk("t4_tmo", 32'(ifc.timed_out), 1);
        chk("t4_drain", 32'(ifc.done), 0);
        idle();
        chk("t4_done", 32'(ifc.done), 1);
        idle();
        idle();
        chk("t4_frozen", ifc.cycles, 50);
        chk("t4_no_halt", 32'(ifc.halted), 0);

        // Asynchronous reset mid-RUN.
        do_reset();
        step(1'b1, SIG, 32'h5, 1'b0);
        step(1'b1, SIG, 32'h6, 1'b0);
        chk("t5_level2", 32'(ifc.level), 2);
        ifc.st_en = 1'b0;
        rst = 1'b1;
        #2;
        chk("t5_valid0", 32'(ifc.rd_valid), 0);
        chk("t5_level0", 32'(ifc.level), 0);
        chk("t5_rd_data0", ifc.rd_data, 0);
        chk("t5_flags0", {28'h0, ifc.overflow, ifc.halted,
                          ifc.timed_out, ifc.done}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, SIG, 32'h77, 1'b0); exp_q.push_back(32'h77);
        chk("t5_resume", 32'(ifc.level), 1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
        chk("t5_cycles", ifc.cycles, 2);

        // Window capture: 0xF3C is in range only with the window enabled.
        do_reset();
        step(1'b1, 32'h0000_0F00, 32'h100, 1'b0);
        exp_q.push_back(32'h100);
        step(1'b1, 32'h0000_0F3C, 32'h200, 1'b0);
`ifdef SIG_RANGE_EN
        exp_q.push_back(32'h200);
`endif
        step(1'b1, 32'h0000_0F40, 32'h300, 1'b0);
`ifdef SIG_RANGE_EN
        chk("t6_level", 32'(ifc.level), 2);
        for (int i = 0; i < 2; i++)
            step(1'b0, 32'h0, 32'h0, 1'b1);
`else
        chk("t6_level", 32'(ifc.level), 1);
        step(1'b0, 32'h0, 32'h0, 1'b1);
`endif
        chk("t6_empty", 32'(ifc.rd_valid), 0);

        idle();
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/sig_capture_ctrl.md
Name: sig_capture_ctrl

Overview:
- Synthesizable successor to the compliance-bench signature/finish logic.
- Snoops the core's data-memory store port and queues signature stores into a FIFO that a drain interface (bench or UART) empties.
- Detects the halt store and enforces a cycle-count timeout.
- Sits beside the data memory in the top level; one instance per core.

Parameters:
- DATA_W, 32, store data width.
- ADDR_W, 32, store address width.
- DEPTH, 16, signature FIFO depth in words; power of 2, at least 2.
- SIG_ADDR, 32'h0000_0F00, signature store address.
- HALT_ADDR, 32'hCAFE_BEEF, halt store address.
- TIMEOUT, 20000, maximum RUN cycles before forced stop; at least 1.
- SIG_SPAN, 64, signature window size in bytes; used only with SIG_RANGE_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- st_en  in  1  store strobe for this cycle (active-high; top ties it to ~wr).
- st_addr  in  ADDR_W  store address (ALU result).
- st_data  in  DATA_W  store data.
- rd_en  in  1  drain pop request.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  DATA_W  FIFO head, first-word fall-through.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky; a signature word was dropped.
- halted  out  1  sticky; halt store seen.
- timed_out  out  1  sticky; TIMEOUT reached.
- done  out  1  stopped and FIFO drained.
- cycles  out  32  RUN cycle count, saturating.

Behaviour:
- Reset (async assert, sync release)
  - FSM enters RUN; FIFO empty.
  - All outputs 0: rd_valid=0, rd_data=0, level=0, overflow=0, halted=0, timed_out=0, done=0, cycles=0.
  - Reset mid-operation discards the FIFO contents and all flags.
- States
  - RUN: capture enabled, cycles increments each clk.
  - DRAIN: capture disabled, cycles frozen, FIFO still poppable.
  - DONE: terminal until reset.
- Signature match: st_en && st_addr==SIG_ADDR.
- Halt match: st_en && st_addr==HALT_ADDR.
- RUN transitions
  - Halt match -> DRAIN at next edge, halted=1. The halt store itself is never queued.
  - cycles reaching TIMEOUT-1 on this edge -> DRAIN, timed_out=1.
  - Halt and timeout on the same cycle: both flags set.
- DRAIN -> DONE when the FIFO is empty. Check made each cycle, so an empty FIFO at halt gives DRAIN for one cycle, then DONE.
- done=1 exactly in DONE.
- Push: a signature match in RUN pushes st_data; visible on rd_valid/rd_data the next cycle (latency 1).
- Pop: rd_en && rd_valid pops the head; rd_en while empty is ignored.
- Push and pop in the same cycle, FIFO non-empty: both occur, level unchanged.
- Push while full
  - With a simultaneous pop: push succeeds.
  - Without a pop: word dropped, overflow=1, FIFO unchanged.
- Pointers are ($clog2(DEPTH)+1)-bit and wrap modulo 2*DEPTH.
  - Full when the pointers differ only in the MSB.
  - Empty when the pointers are equal.
- cycles saturates at 32'hFFFF_FFFF.
- rd_data is registered storage read at the head pointer. Contents are don't-care when rd_valid=0, but rd_data reads 0 after reset.

Optional Feature:
- Macro SIG_RANGE_EN.
- Defined
  - Signature match is st_en && SIG_ADDR <= st_addr < SIG_ADDR+SIG_SPAN, compared unsigned at ADDR_W bits.
  - The window must not contain HALT_ADDR; halt match takes priority if it does.
- Undefined
  - Exact match on SIG_ADDR only.
  - SIG_SPAN unused.

Test Plan:
- Three stores to 0xF00 (0x11, 0x22, 0x33) on consecutive cycles, rd_en=0.
  - Expect level=3 one cycle after the last store.
  - Then pop three times: rd_data 0x11, 0x22, 0x33; rd_valid falls after the third pop.
- DEPTH=4, six stores to 0xF00, no pops.
  - Expect level=4, overflow=1, FIFO holds the first four words.
  - Push+pop on the full FIFO keeps level=4.
- Two signature stores, then a store to 0xCAFEBEEF.
  - Expect halted=1, a later store to 0xF00 is ignored, done=0.
  - After two pops, done=1 on the next cycle.
- TIMEOUT=50, no stores.
  - Expect timed_out=1 and done=1 within 2 cycles after cycles=49; cycles frozen at 50.
- rst asserted mid-RUN with level=2 and no clock edge.
  - Expect rd_valid, level, and flags 0 immediately.
  - After release, capture resumes normally.
- SIG_RANGE_EN defined, SIG_SPAN=64: stores to 0xF00, 0xF3C, 0xF40.
  - Expect only the first two queued.
